vga_timing: RTL and testbench



---
 rtl/vga_timing.sv | 163 ++++++++++++++++
 tb/tb_vga_timing.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster timing for the DE2-115 VGA DAC.
// Publishes the current pixel coordinate to the pixel generator, takes its
// colour back PIPE_LAT cycles later, and drives sync, blank and colour from
// one output register so all DAC pins change on the same edge.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_de,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter-width copies of the raster boundaries
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line entry layout: {hsync, vsync, de}; idle means syncs high, blanked
    localparam logic [2:0] DLY_IDLE = 3'b110;

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        h_wrap;
    logic        frame_end;

    logic        hsync_raw;
    logic        vsync_raw;
    logic        de_raw;
    logic [2:0]  dly_in;
    logic [2:0]  dly_out;

    logic        hsync_q;
    logic        vsync_q;
    logic        blank_n_q;
    logic [7:0]  r_q, g_q, b_q;

    assign h_wrap    = (h_q == H_LAST);
    assign frame_end = h_wrap && (v_q == V_LAST);

    // Next-state for the raster counters and the completed-frame counter
    always_comb begin
        h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d    = v_q;
        fcnt_d = fcnt_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
        if (frame_end) begin
            fcnt_d = fcnt_q + 16'd1;
        end
    end

    // Raster counters; reset parks the beam at the top-left pixel
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q    <= 10'd0;
            v_q    <= 10'd0;
            fcnt_q <= 16'd0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Stage 0: coordinate and strobes are pure decode of the counters
    assign o_x           = h_q;
    assign o_y           = v_q;
    assign de_raw        = (h_q < H_ACT) && (v_q < V_ACT);
    assign o_de          = de_raw;
    assign o_line_start  = (h_q == 10'd0);
    assign o_frame_start = (h_q == 10'd0) && (v_q == 10'd0);
    assign o_frame_cnt   = fcnt_q;

    assign hsync_raw = !((h_q >= HS_BEGIN) && (h_q < HS_END));
    assign vsync_raw = !((v_q >= VS_BEGIN) && (v_q < VS_END));
    assign dly_in    = {hsync_raw, vsync_raw, de_raw};

    // Delay timing flags so they line up with the generator's returning colour
    generate
        if (PIPE_LAT == 0) begin : g_no_dly
            assign dly_out = dly_in;
        end else begin : g_dly
            logic [2:0] dly_q [PIPE_LAT];

            // Shift register; reset flushes stale timing out of the line
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        dly_q[i] <= DLY_IDLE;
                    end
                end else begin
                    dly_q[0] <= dly_in;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign dly_out = dly_q[PIPE_LAT-1];
        end
    endgenerate

    // Output stage: all DAC pins from one register; colour zeroed while blanked
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
        end else begin
            hsync_q   <= dly_out[2];
            vsync_q   <= dly_out[1];
            blank_n_q <= dly_out[0];
            r_q       <= dly_out[0] ? i_r : 8'd0;
            g_q       <= dly_out[0] ? i_g : 8'd0;
            b_q       <= dly_out[0] ? i_b : 8'd0;
        end
    end

    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: one full-size instance (PIPE_LAT=2) plus two reduced
// rasters (PIPE_LAT=2 and PIPE_LAT=0) so whole frames fit in a short run.
// Expected values come from arithmetic on the edge count since reset.
module tb_vga_timing;

    localparam int N = 3;
    localparam int P_HA [N] = '{640, 16, 16};
    localparam int P_HFP[N] = '{16, 4, 4};
    localparam int P_HS [N] = '{96, 6, 6};
    localparam int P_HBP[N] = '{48, 4, 4};
    localparam int P_VA [N] = '{480, 8, 8};
    localparam int P_VFP[N] = '{10, 2, 2};
    localparam int P_VS [N] = '{2, 2, 2};
    localparam int P_VBP[N] = '{33, 3, 3};
    localparam int P_PL [N] = '{2, 2, 0};

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       ls;
        logic       fs;
    } crd_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic       sn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pin_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  ir [N];
    logic [7:0]  ig [N];
    logic [7:0]  ib [N];
    logic [9:0]  ox [N];
    logic [9:0]  oy [N];
    logic        ode[N];
    logic        ols[N];
    logic        ofs[N];
    logic [15:0] ofc[N];
    logic        hs [N];
    logic        vs [N];
    logic        bln[N];
    logic        sn [N];
    logic [7:0]  vr [N];
    logic [7:0]  vg [N];
    logic [7:0]  vb [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            vga_timing #(
                .H_ACTIVE(P_HA[gi]), .H_FP(P_HFP[gi]), .H_SYNC(P_HS[gi]), .H_BP(P_HBP[gi]),
                .V_ACTIVE(P_VA[gi]), .V_FP(P_VFP[gi]), .V_SYNC(P_VS[gi]), .V_BP(P_VBP[gi]),
                .PIPE_LAT(P_PL[gi])
            ) u_dut (
                .i_clk(clk), .i_rst(rst),
                .o_x(ox[gi]), .o_y(oy[gi]), .o_de(ode[gi]),
                .o_line_start(ols[gi]), .o_frame_start(ofs[gi]), .o_frame_cnt(ofc[gi]),
                .i_r(ir[gi]), .i_g(ig[gi]), .i_b(ib[gi]),
                .vga_hsync(hs[gi]), .vga_vsync(vs[gi]), .vga_blank_n(bln[gi]),
                .vga_sync_n(sn[gi]), .vga_r(vr[gi]), .vga_g(vg[gi]), .vga_b(vb[gi])
            );
        end
    endgenerate

    int k;
    int checks;
    int passed;
    int unsigned fbase[N];
    logic prev_hs0, prev_vs1;
    int a_fall1, a_rise1, a_fall2, b_vfall, b_vrise;

    function automatic int ht(input int i);
        return P_HA[i] + P_HFP[i] + P_HS[i] + P_HBP[i];
    endfunction

    function automatic int vt(input int i);
        return P_VA[i] + P_VFP[i] + P_VS[i] + P_VBP[i];
    endfunction

    function automatic int ft(input int i);
        return ht(i) * vt(i);
    endfunction

    // Coordinate outputs after kk edges since reset
    function automatic crd_t mdl_crd(input int i, input int kk);
        crd_t c;
        int   h, v;
        h    = kk % ht(i);
        v    = (kk / ht(i)) % vt(i);
        c.x  = 10'(h);
        c.y  = 10'(v);
        c.de = (h < P_HA[i]) && (v < P_VA[i]);
        c.ls = (h == 0);
        c.fs = (h == 0) && (v == 0);
        return c;
    endfunction

    // DAC pins after kk edges: they reflect the coordinate from PIPE_LAT+1 edges back
    function automatic pin_t mdl_pin(input int i, input int kk, input logic [7:0] r,
                                     input logic [7:0] g, input logic [7:0] b);
        pin_t p;
        int   s, sh, sv;
        logic de;
        s    = kk - 1 - P_PL[i];
        p.sn = 1'b0;
        if (s < 0) begin
            p.hs = 1'b1; p.vs = 1'b1; p.bl = 1'b0;
            p.r  = 8'd0; p.g  = 8'd0; p.b  = 8'd0;
        end else begin
            sh   = s % ht(i);
            sv   = (s / ht(i)) % vt(i);
            de   = (sh < P_HA[i]) && (sv < P_VA[i]);
            p.hs = !((sh >= P_HA[i] + P_HFP[i]) && (sh < P_HA[i] + P_HFP[i] + P_HS[i]));
            p.vs = !((sv >= P_VA[i] + P_VFP[i]) && (sv < P_VA[i] + P_VFP[i] + P_VS[i]));
            p.bl = de;
            p.r  = de ? r : 8'd0;
            p.g  = de ? g : 8'd0;
            p.b  = de ? b : 8'd0;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    // mode 0: random colour, 1: colour = delayed x, 2: 0xAA, 3: all 0xFF
    task automatic step(input logic r_v, input int mode);
        crd_t c;
        pin_t p;
        int   s;
        for (int i = 0; i < N; i++) begin
            ig[i] = 8'($urandom);
            ib[i] = 8'($urandom);
            case (mode)
                1: begin
                    s     = k - P_PL[i];
                    ir[i] = (s >= 0) ? 8'(s % ht(i)) : 8'($urandom);
                end
                2: ir[i] = 8'hAA;
                3: begin ir[i] = 8'hFF; ig[i] = 8'hFF; ib[i] = 8'hFF; end
                default: ir[i] = 8'($urandom);
            endcase
        end
        rst = r_v;
        @(posedge clk);
        k = r_v ? 0 : k + 1;
        if (r_v) begin
            for (int i = 0; i < N; i++) fbase[i] = 0;
            prev_hs0 = 1'b1; prev_vs1 = 1'b1;
            a_fall1 = -1; a_rise1 = -1; a_fall2 = -1; b_vfall = -1; b_vrise = -1;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            c = mdl_crd(i, k);
            p = mdl_pin(i, k, ir[i], ig[i], ib[i]);
            chk($sformatf("coord%0d", i), 64'({ox[i], oy[i], ode[i], ols[i], ofs[i]}), 64'(c));
            chk($sformatf("fcnt%0d", i), 64'(ofc[i]), 64'(16'(fbase[i] + 32'(k / ft(i)))));
            chk($sformatf("pins%0d", i),
                64'({hs[i], vs[i], bln[i], sn[i], vr[i], vg[i], vb[i]}), 64'(p));
        end
        if (prev_hs0 && !hs[0]) begin
            if (a_fall1 < 0) a_fall1 = k;
            else if (a_fall2 < 0) a_fall2 = k;
        end
        if (!prev_hs0 && hs[0] && a_rise1 < 0) a_rise1 = k;
        if (prev_vs1 && !vs[1] && b_vfall < 0) b_vfall = k;
        if (!prev_vs1 && vs[1] && b_vrise < 0) b_vrise = k;
        prev_hs0 = hs[0];
        prev_vs1 = vs[1];
    endtask

    initial begin
        k = 0; checks = 0; passed = 0; rst = 1'b1;
        prev_hs0 = 1'b1; prev_vs1 = 1'b1;
        a_fall1 = -1; a_rise1 = -1; a_fall2 = -1; b_vfall = -1; b_vrise = -1;
        for (int i = 0; i < N; i++) begin
            fbase[i] = 0; ir[i] = 8'd0; ig[i] = 8'd0; ib[i] = 8'd0;
        end

        // Reset hold with full-scale colour on the inputs
        repeat (5) step(1'b1, 3);
        chk("reset blank_n", 64'(bln[0]), 64'd0);
        chk("reset vga_r", 64'(vr[0]), 64'd0);

        // Free run: random colour, then aligned colour, then 0xAA
        repeat (1000) step(1'b0, 0);
        repeat (600)  step(1'b0, 1);
        repeat (100)  step(1'b0, 2);

        chk("A hsync first fall", 64'(a_fall1), 64'(659));
        chk("A hsync first rise", 64'(a_rise1), 64'(755));
        chk("A hsync second fall", 64'(a_fall2), 64'(1459));
        chk("B vsync fall", 64'(b_vfall), 64'(303));
        chk("B vsync low width", 64'(b_vrise - b_vfall), 64'(60));
        chk("C frame count", 64'(ofc[2]), 64'(3));

        // Reset in the middle of vsync on the reduced raster
        while (k % ft(1) != 355) step(1'b0, 0);
        chk("B vsync low before reset", 64'(vs[1]), 64'd0);
        step(1'b1, 0);
        chk("B vsync after reset", 64'(vs[1]), 64'd1);
        chk("B x after reset", 64'(ox[1]), 64'd0);
        chk("B y after reset", 64'(oy[1]), 64'd0);

        // Timing restarts identically after release
        repeat (800) step(1'b0, 0);
        chk("A hsync fall after restart", 64'(a_fall1), 64'(659));
        chk("A hsync rise after restart", 64'(a_rise1), 64'(755));

        // Frame counter wrap on the reduced raster
        force g_dut[1].u_dut.fcnt_q = 16'hFFFF;
        #1;
        release g_dut[1].u_dut.fcnt_q;
        fbase[1] = 32'hFFFF - 32'(k / ft(1));
        chk("B preset frame count", 64'(ofc[1]), 64'h0FFFF);
        while (k % ft(1) != 0) step(1'b0, 0);
        chk("B frame count wrapped", 64'(ofc[1]), 64'd0);
        chk("B x at wrap", 64'(ox[1]), 64'd0);
        chk("B y at wrap", 64'(oy[1]), 64'd0);
        repeat (20) step(1'b0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
